// File: rtl/bch_encoder.sv
// Systematic bit-serial BCH encoder: forwards K message bits, then shifts out the P-bit
// remainder of m(x)*x^P mod g(x) from an LFSR, behind a single registered output stage.
module bch_encoder #(
  parameter int unsigned                  C_MSG_LEN    = 16,
  parameter int unsigned                  C_PARITY_LEN = 15,
  parameter logic [C_PARITY_LEN-1:0]      C_GEN_POLY   = 15'h0FAF
) (
  input  logic I_clk,
  input  logic I_rst_n,
  input  logic I_data,
  input  logic I_data_v,
  output logic O_data_ready,
  output logic O_code,
  output logic O_code_v,
  input  logic I_code_ready,
  output logic O_code_last,
  output logic O_busy
);

  localparam int unsigned MaxLen = (C_MSG_LEN > C_PARITY_LEN) ? C_MSG_LEN : C_PARITY_LEN;
  localparam int unsigned CntW   = $clog2(MaxLen + 1);
  localparam logic [CntW-1:0] MsgLast = CntW'(C_MSG_LEN - 1);
  localparam logic [CntW-1:0] ParLast = CntW'(C_PARITY_LEN - 1);

  typedef enum logic [0:0] {StMsg, StPar} state_e;

  state_e                  state_q, state_d;
  logic [C_PARITY_LEN-1:0] r_q, r_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    code_q, code_d;
  logic                    code_v_q, code_v_d;
  logic                    code_last_q, code_last_d;
  logic                    busy_q, busy_d;

  logic loadable;
  logic out_xfer;
  logic data_ready;
  logic in_xfer;
  logic fb;

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    code_d      = code_q;
    code_v_d    = code_v_q;
    code_last_d = code_last_q;
    busy_d      = busy_q;
    fb          = 1'b0;

    loadable   = !code_v_q || I_code_ready;
    out_xfer   = code_v_q && I_code_ready;
    data_ready = (state_q == StMsg) && loadable;
    in_xfer    = I_data_v && data_ready;

    // Draining the output register; a load below overrides these in the same cycle.
    if (out_xfer) begin
      code_v_d    = 1'b0;
      code_last_d = 1'b0;
      if (code_last_q) begin
        busy_d = 1'b0;
      end
    end

    unique case (state_q)
      StMsg: begin
        if (in_xfer) begin
          code_d      = I_data;
          code_v_d    = 1'b1;
          code_last_d = 1'b0;
          busy_d      = 1'b1;
          fb          = I_data ^ r_q[C_PARITY_LEN-1];
          r_d         = {r_q[C_PARITY_LEN-2:0], 1'b0} ^ (fb ? C_GEN_POLY : '0);
          if (cnt_q == MsgLast) begin
            cnt_d   = '0;
            state_d = StPar;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StPar: begin
        if (loadable) begin
          code_d   = r_q[C_PARITY_LEN-1];
          code_v_d = 1'b1;
          r_d      = {r_q[C_PARITY_LEN-2:0], 1'b0};
          if (cnt_q == ParLast) begin
            code_last_d = 1'b1;
            r_d         = '0;
            cnt_d       = '0;
            state_d     = StMsg;
          end else begin
            code_last_d = 1'b0;
            cnt_d       = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StMsg;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q     <= StMsg;
      r_q         <= '0;
      cnt_q       <= '0;
      code_q      <= 1'b0;
      code_v_q    <= 1'b0;
      code_last_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      code_v_q    <= code_v_d;
      code_last_q <= code_last_d;
      busy_q      <= busy_d;
    end
  end

  assign O_data_ready = data_ready;
  assign O_code       = code_q;
  assign O_code_v     = code_v_q;
  assign O_code_last  = code_last_q;
  assign O_busy       = busy_q;

endmodule

// File: tb/tb_bch_encoder.sv
// Directed and randomized-handshake bench for bch_encoder with BCH(31,16) defaults.
module tb_bch_encoder;

  logic clk;
  logic rst_n;
  logic data;
  logic data_v;
  logic code_ready;
  logic data_ready;
  logic code;
  logic code_v;
  logic code_last;
  logic busy;

  int n_cmp;
  int n_fail;

  bch_encoder dut (
    .I_clk        (clk),
    .I_rst_n      (rst_n),
    .I_data       (data),
    .I_data_v     (data_v),
    .O_data_ready (data_ready),
    .O_code       (code),
    .O_code_v     (code_v),
    .I_code_ready (code_ready),
    .O_code_last  (code_last),
    .O_busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Long division by the full g(x) = x^15 + 0x0FAF (octal 107657).
  function automatic logic [14:0] poly_mod(input logic [30:0] w);
    logic [30:0] d;
    logic [30:0] g;
    d = w;
    g = 31'h8FAF;
    for (int i = 30; i >= 15; i--) begin
      if (d[i]) d = d ^ (g << (i - 15));
    end
    return d[14:0];
  endfunction

  // Drives one frame with the given valid/ready percentages and captures the codeword.
  task automatic run_frame(input logic [15:0] msg, input int vpct, input int rpct,
                           output logic [30:0] cw, output logic [30:0] last_mask,
                           output int cycles, output int rdy_low, output bit timeout);
    int in_idx;
    int out_idx;
    in_idx = 0;
    out_idx = 0;
    cycles = 0;
    rdy_low = 0;
    cw = '0;
    last_mask = '0;
    while (out_idx < 31 && cycles < 2000) begin
      @(posedge clk);
      #1;
      data_v     = (in_idx < 16) && ($urandom_range(99) < vpct);
      data       = (in_idx < 16) ? msg[15 - in_idx] : 1'b0;
      code_ready = ($urandom_range(99) < rpct);
      #1;
      if (!data_ready) rdy_low++;
      if (data_v && data_ready) in_idx++;
      if (code_v && code_ready) begin
        cw[30 - out_idx]        = code;
        last_mask[30 - out_idx] = code_last;
        out_idx++;
      end
      cycles++;
    end
    timeout = (out_idx < 31);
    data_v = 1'b0;
  endtask

  task automatic test_reset();
    code_ready = 1'b0;
    #1;
    n_cmp++; if (code !== 1'b0) begin n_fail++; $display("FAIL reset_code got %b want 0", code); end
    n_cmp++; if (code_v !== 1'b0) begin n_fail++; $display("FAIL reset_code_v got %b want 0", code_v); end
    n_cmp++; if (code_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b want 0", code_last); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (data_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", data_ready); end
  endtask

  task automatic test_all_zero();
    logic [30:0] cw, lm;
    int cyc, rl;
    bit to;
    run_frame(16'h0000, 100, 100, cw, lm, cyc, rl, to);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL zero_timeout got %b want 0", to); end
    n_cmp++; if (cw !== 31'h0) begin n_fail++; $display("FAIL zero_code got %h want 0", cw); end
    n_cmp++; if (lm !== 31'h1) begin n_fail++; $display("FAIL zero_last got %h want 1", lm); end
    n_cmp++; if (cyc !== 32) begin n_fail++; $display("FAIL zero_cycles got %0d want 32", cyc); end
    @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_end got %b want 0", busy); end
  endtask

  task automatic test_vectors();
    logic [15:0] msgs [3];
    logic [14:0] pars [3];
    logic [30:0] cw, lm;
    int cyc, rl;
    bit to;
    msgs[0] = 16'h0001; pars[0] = 15'h0FAF;
    msgs[1] = 16'h0002; pars[1] = 15'h1F5E;
    msgs[2] = 16'h0003; pars[2] = 15'h10F1;
    for (int i = 0; i < 3; i++) begin
      run_frame(msgs[i], 100, 100, cw, lm, cyc, rl, to);
      n_cmp++;
      if (cw !== {msgs[i], pars[i]}) begin
        n_fail++;
        $display("FAIL vec%0d_code got %h want %h", i, cw, {msgs[i], pars[i]});
      end
      n_cmp++; if (rl !== 15) begin n_fail++; $display("FAIL vec%0d_ready_low got %0d want 15", i, rl); end
      n_cmp++; if (lm !== 31'h1) begin n_fail++; $display("FAIL vec%0d_last got %h want 1", i, lm); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] stream;
    logic [61:0] obits;
    int in_idx, out_idx, first_t, last_t, rdy_low;
    stream = {16'h0001, 16'h0003};
    obits = '0;
    in_idx = 0; out_idx = 0; first_t = -1; last_t = -1; rdy_low = 0;
    for (int t = 0; t < 100 && out_idx < 62; t++) begin
      @(posedge clk);
      #1;
      data_v     = (in_idx < 32);
      data       = (in_idx < 32) ? stream[31 - in_idx] : 1'b0;
      code_ready = 1'b1;
      #1;
      if (!data_ready) rdy_low++;
      if (t == 31) begin
        n_cmp++; if (code_last !== 1'b1) begin n_fail++; $display("FAIL b2b_last_t31 got %b want 1", code_last); end
        n_cmp++; if (data_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_t31 got %b want 1", data_ready); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_t31 got %b want 1", busy); end
      end
      if (data_v && data_ready) in_idx++;
      if (code_v && code_ready) begin
        if (first_t < 0) first_t = t;
        obits[61 - out_idx] = code;
        last_t = t;
        out_idx++;
      end
    end
    data_v = 1'b0;
    n_cmp++; if (out_idx !== 62) begin n_fail++; $display("FAIL b2b_count got %0d want 62", out_idx); end
    n_cmp++; if (first_t !== 1) begin n_fail++; $display("FAIL b2b_first got %0d want 1", first_t); end
    n_cmp++; if (last_t !== 62) begin n_fail++; $display("FAIL b2b_lastcyc got %0d want 62", last_t); end
    n_cmp++; if (rdy_low !== 30) begin n_fail++; $display("FAIL b2b_ready_low got %0d want 30", rdy_low); end
    n_cmp++;
    if (obits !== {16'h0001, 15'h0FAF, 16'h0003, 15'h10F1}) begin
      n_fail++;
      $display("FAIL b2b_code got %h want %h", obits, {16'h0001, 15'h0FAF, 16'h0003, 15'h10F1});
    end
    @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    logic [30:0] cw;
    int in_idx, out_idx;
    cw = '0;
    in_idx = 0; out_idx = 0;
    for (int t = 0; t < 100 && out_idx < 31; t++) begin
      @(posedge clk);
      #1;
      data_v     = (in_idx < 16);
      data       = (in_idx == 15);
      code_ready = !(t >= 20 && t < 25);
      #1;
      if (t >= 20 && t < 25) begin
        // Fourth parity bit of 0x0FAF is 1 and must hold through the stall.
        n_cmp++; if (code !== 1'b1) begin n_fail++; $display("FAIL bp_hold_t%0d got %b want 1", t, code); end
        n_cmp++; if (code_v !== 1'b1) begin n_fail++; $display("FAIL bp_valid_t%0d got %b want 1", t, code_v); end
        n_cmp++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_t%0d got %b want 0", t, data_ready); end
      end
      if (data_v && data_ready) in_idx++;
      if (code_v && code_ready) begin
        cw[30 - out_idx] = code;
        out_idx++;
      end
    end
    data_v = 1'b0;
    n_cmp++; if (out_idx !== 31) begin n_fail++; $display("FAIL bp_count got %0d want 31", out_idx); end
    n_cmp++;
    if (cw !== {16'h0001, 15'h0FAF}) begin
      n_fail++;
      $display("FAIL bp_code got %h want %h", cw, {16'h0001, 15'h0FAF});
    end
  endtask

  task automatic test_reset_mid();
    logic [30:0] cw, lm;
    int cyc, rl, in_idx;
    bit to;
    in_idx = 0;
    for (int t = 0; t < 40 && in_idx < 9; t++) begin
      @(posedge clk);
      #1;
      data_v = 1'b1;
      data = 1'b1;
      code_ready = 1'b1;
      #1;
      if (data_v && data_ready) in_idx++;
    end
    @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_pre got %b want 1", busy); end
    rst_n = 1'b0;
    data_v = 1'b0;
    code_ready = 1'b0;
    #1;
    n_cmp++; if (code_v !== 1'b0) begin n_fail++; $display("FAIL mid_code_v got %b want 0", code_v); end
    n_cmp++; if (code !== 1'b0) begin n_fail++; $display("FAIL mid_code got %b want 0", code); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b want 0", busy); end
    n_cmp++; if (code_last !== 1'b0) begin n_fail++; $display("FAIL mid_last got %b want 0", code_last); end
    n_cmp++; if (data_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready got %b want 1", data_ready); end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    run_frame(16'h0001, 100, 100, cw, lm, cyc, rl, to);
    n_cmp++;
    if (cw !== {16'h0001, 15'h0FAF}) begin
      n_fail++;
      $display("FAIL mid_after_code got %h want %h", cw, {16'h0001, 15'h0FAF});
    end
  endtask

  task automatic test_random();
    logic [15:0] msg;
    logic [30:0] cw, lm, exp_cw;
    int cyc, rl;
    bit to;
    for (int f = 0; f < 200; f++) begin
      msg = 16'($urandom);
      run_frame(msg, 60, 60, cw, lm, cyc, rl, to);
      exp_cw = {msg, poly_mod({msg, 15'b0})};
      n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_timeout got %b want 0", f, to); end
      n_cmp++; if (cw !== exp_cw) begin n_fail++; $display("FAIL rnd%0d_code got %h want %h", f, cw, exp_cw); end
      n_cmp++;
      if (poly_mod(cw) !== 15'h0) begin
        n_fail++;
        $display("FAIL rnd%0d_divisible got %h want 0", f, poly_mod(cw));
      end
      n_cmp++; if (lm !== 31'h1) begin n_fail++; $display("FAIL rnd%0d_last got %h want 1", f, lm); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    data = 1'b0;
    data_v = 1'b0;
    code_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    test_reset();
    test_all_zero();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bch_encoder.md
# bch_encoder

Systematic, bit-serial binary BCH encoder on the transmit side of the PUF helper-data path; it produces the codewords that the syndrome and error-locator decode chain later corrects. Each frame accepts C_MSG_LEN message bits and passes them through unchanged. It then appends C_PARITY_LEN parity bits, the remainder of m(x)·x^P mod g(x), computed in an LFSR. Both input and output use valid/ready handshakes, with one registered output stage.

## Interface
- C_MSG_LEN, 16: message bits per frame (K).
- C_PARITY_LEN, 15: parity bits per frame (P); the codeword length is N = K + P (31 by default).
- C_GEN_POLY, 15'h0FAF: generator polynomial g(x) without the leading x^P term. Bit i is the coefficient of x^i. The default is BCH(31,16,t=3), octal 107657.
- I_clk  in  1  clock; all logic samples on the rising edge.
- I_rst_n  in  1  asynchronous, active-low reset.
- I_data  in  1  message bit; the first bit is the coefficient of x^(N-1).
- I_data_v  in  1  I_data is valid.
- O_data_ready  out  1  the encoder accepts I_data this cycle.
- O_code  out  1  codeword bit, most significant first.
- O_code_v  out  1  O_code is valid.
- I_code_ready  in  1  the downstream block consumes O_code this cycle.
- O_code_last  out  1  qualifies the final parity bit of a frame.
- O_busy  out  1  high from the first message accept until the last parity bit is consumed.

## Operation
- Transfers:
  - Input transfer: I_data_v && O_data_ready.
  - Output transfer: O_code_v && I_code_ready.
  - The output register is loadable when !O_code_v || I_code_ready.
- Counter cnt has width ceil(log2(max(K,P)+1)) and counts accepted bits within the current state.
- State MSG (the reset state):
  - O_data_ready = loadable.
  - On an input transfer:
    - The output register loads I_data and O_code_v is set.
    - fb = I_data ^ r[P-1].
    - r <= {r[P-2:0],1'b0} ^ (fb ? C_GEN_POLY : 0).
    - cnt increments.
  - On the K-th transfer: cnt clears and the state moves to PAR.
- State PAR:
  - O_data_ready = 0.
  - Each cycle the register is loadable:
    - The output register loads r[P-1] and O_code_v is set.
    - r shifts left with zero fill.
    - cnt increments.
  - On the P-th load:
    - O_code_last is set along with that bit.
    - r and cnt are cleared.
    - The state returns to MSG.
- O_code_v is cleared on an output transfer when no new load occurs in the same cycle.
- O_code_last is cleared when that bit transfers.
- O_busy:
  - Set on the first message accept.
  - Cleared on the output transfer of the bit with O_code_last.
- Simultaneous output transfer and load in the same cycle: the new bit replaces the old one and O_code_v stays high.
- I_data is ignored while O_data_ready = 0, including throughout PAR.
- Reset asserted mid-frame:
  - The state, r, cnt and the output register clear immediately.
  - The partial frame is discarded.
  - After release, the next accepted bit is treated as message bit 0.
- Reset values: O_code = 0, O_code_v = 0, O_code_last = 0, O_busy = 0, O_data_ready = 1 after release when the output is empty.

## Timing
- Latency: an accepted input bit appears on O_code the next cycle.
- The first parity bit appears the cycle after the K-th message bit.
- With I_data_v and I_code_ready held high:
  - The K message bits are accepted on consecutive cycles.
  - O_data_ready is low for exactly P cycles.
  - The output stream is gapless, N bits per N cycles.
  - O_data_ready returns high the cycle after the last parity bit loads, so the next frame follows without an output bubble.
- Backpressure:
  - While I_code_ready = 0 and O_code_v = 1, O_code, O_code_last, r and cnt hold.
  - O_data_ready = 0 in this condition.
- All outputs are registered except O_data_ready. O_data_ready is combinational from state, O_code_v and I_code_ready.

## Test plan
- All-zero message, I_code_ready high: 31 zero output bits on consecutive cycles; O_code_last high on bit 30 only.
- Message 16'h0001 (only the last message bit is 1): output is 15 zeros, then 1, then parity 000_1111_1010_1111 MSB first, i.e. 15'h0FAF.
- 200 random messages with random I_data_v and I_code_ready gaps:
  - The output equals a reference model of m·x^15 mod g.
  - Every codeword is divisible by g(x).
  - No bits are lost or duplicated.
- Back-to-back frames with continuous valid and ready: frame 2 bit 0 appears the cycle after frame 1's last parity bit; O_data_ready is low for exactly 15 cycles per frame.
- I_code_ready low for 5 cycles during PAR, then high: the parity bit is held stable and the parity stream resumes intact.
- I_rst_n pulsed low at message bit 9:
  - Outputs go to their reset values at once.
  - A following 16'h0001 frame yields parity 15'h0FAF.
